prf_multiport_sb: RTL

//  Parametrised physical register file for the integer backend with a per-preg ready scoreboard.

---
 rtl/prf_multiport_sb_if.sv | 41 ++++
 rtl/prf_multiport_sb.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/prf_multiport_sb_if.sv
// Port bundle for prf_multiport_sb.
// slave  : the register file side (takes requests, returns read data / ready / debug taps).
// master : the rename/issue/writeback side.
// Signals: rd_en/rd_idx -> rd_data/rd_valid (registered read),
//          wr_en/wr_idx/wr_data (writeback), alloc_en/alloc_idx (scoreboard clear),
//          rq_idx -> rq_ready (combinational ready query), wr_conflict (registered pulse),
//          dbg_idx -> dbg_data (combinational arch-state taps).
interface prf_multiport_sb_if #(
   parameter int unsigned DATA_W    = 64,
   parameter int unsigned PREG_W    = 6,
   parameter int unsigned NUM_RD    = 4,
   parameter int unsigned NUM_WR    = 2,
   parameter int unsigned NUM_ALLOC = 2,
   parameter int unsigned NUM_RQ    = 4,
   parameter int unsigned NUM_DBG   = 32
);
   logic [NUM_RD-1:0]           rd_en;
   logic [NUM_RD*PREG_W-1:0]    rd_idx;
   logic [NUM_RD*DATA_W-1:0]    rd_data;
   logic [NUM_RD-1:0]           rd_valid;
   logic [NUM_WR-1:0]           wr_en;
   logic [NUM_WR*PREG_W-1:0]    wr_idx;
   logic [NUM_WR*DATA_W-1:0]    wr_data;
   logic [NUM_ALLOC-1:0]        alloc_en;
   logic [NUM_ALLOC*PREG_W-1:0] alloc_idx;
   logic [NUM_RQ*PREG_W-1:0]    rq_idx;
   logic [NUM_RQ-1:0]           rq_ready;
   logic                        wr_conflict;
   logic [NUM_DBG*PREG_W-1:0]   dbg_idx;
   logic [NUM_DBG*DATA_W-1:0]   dbg_data;

   modport slave (
      input  rd_en, rd_idx, wr_en, wr_idx, wr_data, alloc_en, alloc_idx, rq_idx, dbg_idx,
      output rd_data, rd_valid, rq_ready, wr_conflict, dbg_data
   );

   modport master (
      output rd_en, rd_idx, wr_en, wr_idx, wr_data, alloc_en, alloc_idx, rq_idx, dbg_idx,
      input  rd_data, rd_valid, rq_ready, wr_conflict, dbg_data
   );
endinterface

// File: rtl/prf_multiport_sb.sv
// Physical register file with per-preg ready scoreboard.
// Ports: clock (rising edge), reset_n (synchronous, active-low), bus (prf_multiport_sb_if.slave).
// Reads are registered (1-cycle latency) and bypass same-cycle writeback data.
// Preg 0 reads as zero and is always ready. Highest-numbered write port wins on index collisions;
// an alloc on the same preg as a write leaves the preg not ready but still takes the data.
module prf_multiport_sb #(
   parameter int unsigned DATA_W    = 64,
   parameter int unsigned NUM_PREGS = 64,
   parameter int unsigned PREG_W    = 6,
   parameter int unsigned NUM_RD    = 4,
   parameter int unsigned NUM_WR    = 2,
   parameter int unsigned NUM_ALLOC = 2,
   parameter int unsigned NUM_RQ    = 4,
   parameter int unsigned NUM_DBG   = 32
) (
   input logic               clock,
   input logic               reset_n,
   prf_multiport_sb_if.slave bus
);

   logic [DATA_W-1:0]    mem_q [NUM_PREGS];
   logic [DATA_W-1:0]    mem_d [NUM_PREGS];
   logic [NUM_PREGS-1:0] ready_q, ready_d;
   logic [DATA_W-1:0]    rd_data_q [NUM_RD];
   logic [DATA_W-1:0]    rd_data_d [NUM_RD];
   logic [NUM_RD-1:0]    rd_valid_q, rd_valid_d;
   logic                 conflict_q, conflict_d;
   logic [NUM_RQ-1:0]    rq_ready;

   logic [PREG_W-1:0] rd_idx_a    [NUM_RD];
   logic [PREG_W-1:0] wr_idx_a    [NUM_WR];
   logic [DATA_W-1:0] wr_data_a   [NUM_WR];
   logic [PREG_W-1:0] alloc_idx_a [NUM_ALLOC];
   logic [PREG_W-1:0] rq_idx_a    [NUM_RQ];
   logic [PREG_W-1:0] dbg_idx_a   [NUM_DBG];

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      assign rd_idx_a[k] = bus.rd_idx[k*PREG_W +: PREG_W];
      assign bus.rd_data[k*DATA_W +: DATA_W] = rd_data_q[k];
   end
   for (genvar j = 0; j < NUM_WR; j++) begin : g_wr
      assign wr_idx_a[j]  = bus.wr_idx[j*PREG_W +: PREG_W];
      assign wr_data_a[j] = bus.wr_data[j*DATA_W +: DATA_W];
   end
   for (genvar a = 0; a < NUM_ALLOC; a++) begin : g_alloc
      assign alloc_idx_a[a] = bus.alloc_idx[a*PREG_W +: PREG_W];
   end
   for (genvar q = 0; q < NUM_RQ; q++) begin : g_rq
      assign rq_idx_a[q] = bus.rq_idx[q*PREG_W +: PREG_W];
   end
   // Debug taps see the array only; in-flight writes are deliberately not bypassed.
   for (genvar d = 0; d < NUM_DBG; d++) begin : g_dbg
      assign dbg_idx_a[d] = bus.dbg_idx[d*PREG_W +: PREG_W];
      assign bus.dbg_data[d*DATA_W +: DATA_W] = mem_q[dbg_idx_a[d]];
   end

   assign bus.rd_valid    = rd_valid_q;
   assign bus.wr_conflict = conflict_q;
   assign bus.rq_ready    = rq_ready;

   // Array and scoreboard next state: writes in port order (last wins), then allocs override ready.
   always_comb begin
      mem_d   = mem_q;
      ready_d = ready_q;
      for (int unsigned j = 0; j < NUM_WR; j++) begin
         if (bus.wr_en[j] && (wr_idx_a[j] != '0)) begin
            mem_d[wr_idx_a[j]]   = wr_data_a[j];
            ready_d[wr_idx_a[j]] = 1'b1;
         end
      end
      for (int unsigned a = 0; a < NUM_ALLOC; a++) begin
         if (bus.alloc_en[a] && (alloc_idx_a[a] != '0)) begin
            ready_d[alloc_idx_a[a]] = 1'b0;
         end
      end
   end

   // Read stage with writeback bypass; idle ports hold their last data.
   always_comb begin
      for (int unsigned k = 0; k < NUM_RD; k++) begin
         rd_data_d[k]  = rd_data_q[k];
         rd_valid_d[k] = 1'b0;
         if (bus.rd_en[k]) begin
            rd_valid_d[k] = 1'b1;
            if (rd_idx_a[k] == '0) begin
               rd_data_d[k] = '0;
            end else begin
               rd_data_d[k] = mem_q[rd_idx_a[k]];
               for (int unsigned j = 0; j < NUM_WR; j++) begin
                  if (bus.wr_en[j] && (wr_idx_a[j] == rd_idx_a[k])) begin
                     rd_data_d[k] = wr_data_a[j];
                  end
               end
            end
         end
      end
   end

   always_comb begin
      conflict_d = 1'b0;
      for (int unsigned j = 0; j < NUM_WR; j++) begin
         for (int unsigned m = j + 1; m < NUM_WR; m++) begin
            if (bus.wr_en[j] && bus.wr_en[m] && (wr_idx_a[j] == wr_idx_a[m])
                && (wr_idx_a[j] != '0)) begin
               conflict_d = 1'b1;
            end
         end
      end
   end

   // Ready query: a writeback landing this cycle counts as ready; same-cycle allocs do not show.
   always_comb begin
      rq_ready = '0;
      for (int unsigned q = 0; q < NUM_RQ; q++) begin
         rq_ready[q] = ready_q[rq_idx_a[q]];
         for (int unsigned j = 0; j < NUM_WR; j++) begin
            if (bus.wr_en[j] && (wr_idx_a[j] == rq_idx_a[q])) begin
               rq_ready[q] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < NUM_PREGS; i++) begin
            mem_q[i] <= '0;
         end
         for (int unsigned k = 0; k < NUM_RD; k++) begin
            rd_data_q[k] <= '0;
         end
         ready_q    <= '1;
         rd_valid_q <= '0;
         conflict_q <= 1'b0;
      end else begin
         mem_q      <= mem_d;
         ready_q    <= ready_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         conflict_q <= conflict_d;
      end
   end

   // Index range checks; only meaningful when NUM_PREGS is not a power of two.
   always_ff @(posedge clock) begin
      if (reset_n) begin
         for (int unsigned k = 0; k < NUM_RD; k++) begin
            if (bus.rd_en[k]) assert (32'(rd_idx_a[k]) < NUM_PREGS);
         end
         for (int unsigned j = 0; j < NUM_WR; j++) begin
            if (bus.wr_en[j]) assert (32'(wr_idx_a[j]) < NUM_PREGS);
         end
         for (int unsigned a = 0; a < NUM_ALLOC; a++) begin
            if (bus.alloc_en[a]) assert (32'(alloc_idx_a[a]) < NUM_PREGS);
         end
         for (int unsigned q = 0; q < NUM_RQ; q++) begin
            assert (32'(rq_idx_a[q]) < NUM_PREGS);
         end
         for (int unsigned d = 0; d < NUM_DBG; d++) begin
            assert (32'(dbg_idx_a[d]) < NUM_PREGS);
         end
      end
   end

endmodule
